bcw_burst_mgr: RTL and testbench

Parametrised multi-channel BCW manager, successor to the single-register BCW update manager. Accepts BCW words over a valid/ready stream, framed into bursts by a last flag and tagged with a target channel. Buffers the words in a FIFO and issues them to the CA distributor with a valid/ready handshake. Enforces a programmable minimum gap between bursts and reports sticky errors and a burst-completion count.

---
 rtl/bcw_burst_mgr.sv | 192 +++++++++++++++++++
 tb/tb_bcw_burst_mgr.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcw_burst_mgr.sv
// bcw_burst_mgr: multi-channel BCW burst manager.
// Accepts BCW words framed into bursts (wr_last) and tagged with a channel.
// It buffers them in a FIFO and issues them to the CA distributor over a
// valid/ready handshake. A programmable idle gap is enforced after every
// burst. It also reports sticky errors and counts completed bursts.
//
// Optional feature macro: BCW_BURST_MGR_PARITY_EN adds wr_par / bcw_par /
// err_parity. wr_par is even parity over wr_data and is carried with the word.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   wr_valid/ready/data/ch/last    input word stream
//   bcw_valid/ready/data/ch/last   output word stream to CA distributor
//   gap_cfg               minimum idle cycles between bursts (0 = none)
//   busy                  FIFO non-empty or FSM not idle
//   fifo_level            entries currently held
//   burst_done_cnt        bursts fully issued (wrapping)
//   err_burst_len, err_ch sticky error flags, cleared by err_clr
module bcw_burst_mgr #(
  parameter int unsigned BCW_WIDTH  = 32,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned BURST_MAX  = 4,
  parameter int unsigned GAP_W      = 4,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [BCW_WIDTH-1:0] wr_data,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic                 wr_last,
  output logic                 bcw_valid,
  input  logic                 bcw_ready,
  output logic [BCW_WIDTH-1:0] bcw_data,
  output logic [CH_W-1:0]      bcw_ch,
  output logic                 bcw_last,
  input  logic [GAP_W-1:0]     gap_cfg,
  output logic                 busy,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [15:0]          burst_done_cnt,
  output logic                 err_burst_len,
  output logic                 err_ch,
  input  logic                 err_clr
`ifdef BCW_BURST_MGR_PARITY_EN
  ,
  input  logic                 wr_par,
  output logic                 bcw_par,
  output logic                 err_parity
`endif
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);
`ifdef BCW_BURST_MGR_PARITY_EN
  localparam int unsigned ENT_W = BCW_WIDTH + CH_W + 2;
`else
  localparam int unsigned ENT_W = BCW_WIDTH + CH_W + 1;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state;
  logic [GAP_W-1:0]   gap_cnt;
  logic [CNT_W-1:0]   word_cnt;
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [ENT_W-1:0]   mem [FIFO_DEPTH];

  logic               full;
  logic               empty;
  logic               accept;
  logic               ch_bad;
  logic               drop;
  logic               push;
  logic               pop;
  logic               last_in;
  logic [ENT_W-1:0]   entry;
  logic [ENT_W-1:0]   head;

  // Handshake and storage decisions for the incoming word.
  always_comb begin
    full    = (fifo_level == LVL_W'(FIFO_DEPTH));
    empty   = (fifo_level == '0);
    accept  = wr_valid & wr_ready;
    ch_bad  = (32'(wr_ch) >= NUM_CH);
    // Counter at BURST_MAX: the burst already ended with a forced last, so
    // everything up to and including the real wr_last is discarded.
    drop    = (word_cnt == CNT_W'(BURST_MAX));
    push    = accept & !ch_bad & !drop;
    last_in = wr_last | (word_cnt == CNT_W'(BURST_MAX - 1));
    pop     = bcw_valid & bcw_ready;
`ifdef BCW_BURST_MGR_PARITY_EN
    entry   = {wr_par, last_in, wr_ch, wr_data};
`else
    entry   = {last_in, wr_ch, wr_data};
`endif
    // Zero the head view while empty so the outputs read 0 after reset.
    head    = empty ? '0 : mem[rd_ptr];
  end

  assign wr_ready  = !full;
  assign bcw_valid = !empty & (state != ST_GAP);
  assign bcw_data  = head[BCW_WIDTH-1:0];
  assign bcw_ch    = head[BCW_WIDTH +: CH_W];
  assign bcw_last  = head[BCW_WIDTH + CH_W];
  assign busy      = !empty | (state != ST_IDLE);
`ifdef BCW_BURST_MGR_PARITY_EN
  assign bcw_par   = head[BCW_WIDTH + CH_W + 1];
`endif

  // FIFO storage; contents need no reset because level gates the head view.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= entry;
    end
  end

  // Pointers, level, word counter, FSM, burst counter and sticky errors.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      gap_cnt        <= '0;
      word_cnt       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_level     <= '0;
      burst_done_cnt <= '0;
      err_burst_len  <= 1'b0;
      err_ch         <= 1'b0;
`ifdef BCW_BURST_MGR_PARITY_EN
      err_parity     <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase

      // Burst framing follows wr_last even for dropped or bad-channel words.
      if (accept) begin
        if (wr_last)   word_cnt <= '0;
        else if (push) word_cnt <= word_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE, ST_ISSUE: begin
          if (pop) begin
            if (!bcw_last) begin
              state <= ST_ISSUE;
            end else if (gap_cfg != '0) begin
              state   <= ST_GAP;
              gap_cnt <= gap_cfg;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          gap_cnt <= gap_cnt - GAP_W'(1);
          if (gap_cnt == GAP_W'(1)) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (pop & bcw_last) burst_done_cnt <= burst_done_cnt + 16'd1;

      // err_clr wins over a same-cycle error event.
      if (err_clr)              err_burst_len <= 1'b0;
      else if (accept & drop)   err_burst_len <= 1'b1;

      if (err_clr)              err_ch <= 1'b0;
      else if (accept & ch_bad) err_ch <= 1'b1;

`ifdef BCW_BURST_MGR_PARITY_EN
      if (err_clr)                             err_parity <= 1'b0;
      else if (accept & (^{wr_data, wr_par}))  err_parity <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_bcw_burst_mgr.sv
// Directed testbench for bcw_burst_mgr (NUM_CH=3 so CH_W=2, other defaults).
module tb_bcw_burst_mgr;

  localparam int unsigned BW    = 32;
  localparam int unsigned CHW   = 2;
  localparam int unsigned LVLW  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_valid;
  logic            wr_ready;
  logic [BW-1:0]   wr_data;
  logic [CHW-1:0]  wr_ch;
  logic            wr_last;
  logic            bcw_valid;
  logic            bcw_ready;
  logic [BW-1:0]   bcw_data;
  logic [CHW-1:0]  bcw_ch;
  logic            bcw_last;
  logic [3:0]      gap_cfg;
  logic            busy;
  logic [LVLW-1:0] fifo_level;
  logic [15:0]     burst_done_cnt;
  logic            err_burst_len;
  logic            err_ch;
  logic            err_clr;
`ifdef BCW_BURST_MGR_PARITY_EN
  logic            wr_par;
  logic            bcw_par;
  logic            err_parity;
`endif

  int errors = 0;
  int checks = 0;

  bcw_burst_mgr #(
    .BCW_WIDTH (32),
    .NUM_CH    (3),
    .FIFO_DEPTH(8),
    .BURST_MAX (4),
    .GAP_W     (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .wr_ch         (wr_ch),
    .wr_last       (wr_last),
    .bcw_valid     (bcw_valid),
    .bcw_ready     (bcw_ready),
    .bcw_data      (bcw_data),
    .bcw_ch        (bcw_ch),
    .bcw_last      (bcw_last),
    .gap_cfg       (gap_cfg),
    .busy          (busy),
    .fifo_level    (fifo_level),
    .burst_done_cnt(burst_done_cnt),
    .err_burst_len (err_burst_len),
    .err_ch        (err_ch),
    .err_clr       (err_clr)
`ifdef BCW_BURST_MGR_PARITY_EN
    ,
    .wr_par        (wr_par),
    .bcw_par       (bcw_par),
    .err_parity    (err_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [BW-1:0] d, input logic [CHW-1:0] c, input logic l);
    wr_data  = d;
    wr_ch    = c;
    wr_last  = l;
`ifdef BCW_BURST_MGR_PARITY_EN
    wr_par   = ^d;
`endif
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_ch     = '0;
    wr_last   = 1'b0;
    bcw_ready = 1'b0;
    gap_cfg   = '0;
    err_clr   = 1'b0;
`ifdef BCW_BURST_MGR_PARITY_EN
    wr_par    = 1'b0;
`endif
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    check("rst_wr_ready",   64'(wr_ready), 64'd1);
    check("rst_bcw_valid",  64'(bcw_valid), 64'd0);
    check("rst_bcw_data",   64'(bcw_data), 64'd0);
    check("rst_bcw_ch",     64'(bcw_ch), 64'd0);
    check("rst_bcw_last",   64'(bcw_last), 64'd0);
    check("rst_busy",       64'(busy), 64'd0);
    check("rst_level",      64'(fifo_level), 64'd0);
    check("rst_done_cnt",   64'(burst_done_cnt), 64'd0);
    check("rst_err_len",    64'(err_burst_len), 64'd0);
    check("rst_err_ch",     64'(err_ch), 64'd0);

    // Single word, one-cycle latency to bcw_valid
    push(32'hA5A5_0001, 2'd1, 1'b1);
    check("single_valid",   64'(bcw_valid), 64'd1);
    check("single_data",    64'(bcw_data), 64'hA5A5_0001);
    check("single_ch",      64'(bcw_ch), 64'd1);
    check("single_last",    64'(bcw_last), 64'd1);
    check("single_level",   64'(fifo_level), 64'd1);
    check("single_busy",    64'(busy), 64'd1);
    bcw_ready = 1'b1;
    tick();
    bcw_ready = 1'b0;
    check("single_done",    64'(burst_done_cnt), 64'd1);
    check("single_busy0",   64'(busy), 64'd0);
    check("single_valid0",  64'(bcw_valid), 64'd0);

    // Gap enforcement: 3 idle cycles between two 1-word bursts
    gap_cfg   = 4'd3;
    bcw_ready = 1'b1;
    push(32'h0000_00B1, 2'd0, 1'b1);
    check("gap_first_valid", 64'(bcw_valid), 64'd1);
    check("gap_first_data",  64'(bcw_data), 64'hB1);
    push(32'h0000_00B2, 2'd2, 1'b1);
    gap_cfg = 4'd0;  // must not affect the gap already loaded
    check("gap_idle1",       64'(bcw_valid), 64'd0);
    check("gap_busy",        64'(busy), 64'd1);
    tick();
    check("gap_idle2",       64'(bcw_valid), 64'd0);
    tick();
    check("gap_idle3",       64'(bcw_valid), 64'd0);
    tick();
    check("gap_second_valid", 64'(bcw_valid), 64'd1);
    check("gap_second_data",  64'(bcw_data), 64'hB2);
    tick();
    check("gap_nogap_busy",   64'(busy), 64'd0);
    check("gap_done",         64'(burst_done_cnt), 64'd3);
    bcw_ready = 1'b0;

    // Full / backpressure: 9 pushes into 8 entries
    for (int i = 0; i < 9; i++) begin
      wr_data  = 32'h100 + 32'(i);
      wr_ch    = 2'd0;
      wr_last  = 1'b1;
`ifdef BCW_BURST_MGR_PARITY_EN
      wr_par   = ^wr_data;
`endif
      wr_valid = 1'b1;
      check("full_wr_ready", 64'(wr_ready), (i < 8) ? 64'd1 : 64'd0);
      tick();
    end
    wr_valid = 1'b0;
    check("full_level",     64'(fifo_level), 64'd8);
    check("full_ready0",    64'(wr_ready), 64'd0);
    bcw_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("full_pop_valid", 64'(bcw_valid), 64'd1);
      check("full_pop_data",  64'(bcw_data), 64'h100 + 64'(i));
      tick();
    end
    bcw_ready = 1'b0;
    check("full_drained",   64'(fifo_level), 64'd0);
    check("full_done",      64'(burst_done_cnt), 64'd11);

    // Overlong burst: 6 words, last on the 6th
    for (int i = 0; i < 6; i++) begin
      push(32'h200 + 32'(i), 2'd1, (i == 5));
    end
    check("long_level",     64'(fifo_level), 64'd4);
    check("long_err",       64'(err_burst_len), 64'd1);
    bcw_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("long_data",    64'(bcw_data), 64'h200 + 64'(i));
      check("long_last",    64'(bcw_last), (i == 3) ? 64'd1 : 64'd0);
      tick();
    end
    bcw_ready = 1'b0;
    check("long_done",      64'(burst_done_cnt), 64'd12);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("long_err_clr",   64'(err_burst_len), 64'd0);

    // Bad channel: ch=3 with NUM_CH=3 is discarded
    push(32'h300, 2'd3, 1'b0);
    check("badch_err",      64'(err_ch), 64'd1);
    check("badch_level",    64'(fifo_level), 64'd0);
    push(32'h301, 2'd2, 1'b1);
    check("badch_next_level", 64'(fifo_level), 64'd1);
    check("badch_next_data",  64'(bcw_data), 64'h301);
    check("badch_next_ch",    64'(bcw_ch), 64'd2);
    // err_clr beats a same-cycle bad-channel event
    err_clr = 1'b1;
    push(32'h302, 2'd3, 1'b1);
    err_clr = 1'b0;
    check("badch_clr_prio", 64'(err_ch), 64'd0);
    check("badch_clr_level", 64'(fifo_level), 64'd1);
    bcw_ready = 1'b1;
    tick();
    bcw_ready = 1'b0;
    check("badch_done",     64'(burst_done_cnt), 64'd13);

    // Reset mid-burst
    push(32'h400, 2'd0, 1'b0);
    push(32'h401, 2'd0, 1'b0);
    check("mid_level",      64'(fifo_level), 64'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_level",  64'(fifo_level), 64'd0);
    check("mid_rst_valid",  64'(bcw_valid), 64'd0);
    check("mid_rst_done",   64'(burst_done_cnt), 64'd0);
    check("mid_rst_busy",   64'(busy), 64'd0);
    // Word counter restarts: a 4-word burst keeps its own last
    push(32'h500, 2'd1, 1'b0);
    push(32'h501, 2'd1, 1'b0);
    push(32'h502, 2'd1, 1'b0);
    push(32'h503, 2'd1, 1'b1);
    check("post_rst_level", 64'(fifo_level), 64'd4);
    check("post_rst_err",   64'(err_burst_len), 64'd0);
    check("post_rst_head",  64'(bcw_data), 64'h500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
